// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MIPS-style multiply/divide unit with HI/LO
// registers. Radix-2 shift-add multiply and restoring divide, one step per
// cycle, followed by a single sign-correction cycle. MFHI/MFLO results are
// returned through a registered valid/ready output stage.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_op1,
  input  logic [DATA_WIDTH-1:0] in_op2,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  busy
);

  localparam int W = DATA_WIDTH;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;

  state_t state;
  state_t next_state;

  logic [CNT_WIDTH-1:0] cnt;
  logic [W-1:0]         hi;
  logic [W-1:0]         lo;

  // Shared working register: MUL keeps {partial product, multiplier},
  // DIV keeps {remainder, dividend/quotient}.
  logic [2*W-1:0] prod;
  logic [W-1:0]   opnd;      // multiplicand or divisor magnitude
  logic           neg_lo;    // negate product / quotient in FIX
  logic           neg_hi;    // remainder takes the dividend's sign
  logic           div_zero;
  logic           op_is_div;

  logic accept;
  logic is_signed;
  logic is_mul;
  logic is_div;
  logic [W-1:0] a_mag;
  logic [W-1:0] b_mag;

  logic [W:0]     add_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     div_shift;
  logic [W:0]     div_diff;
  logic           div_ge;
  logic [2*W-1:0] div_next;
  logic [2*W-1:0] mul_fixed;
  logic [W-1:0]   quo_fixed;
  logic [W-1:0]   rem_fixed;

  assign busy     = (state != IDLE);
  assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  assign is_mul    = (in_op == OP_MULT) || (in_op == OP_MULTU);
  assign is_div    = (in_op == OP_DIV)  || (in_op == OP_DIVU);
  assign is_signed = (in_op == OP_MULT) || (in_op == OP_DIV);
  assign a_mag     = (is_signed && in_op1[W-1]) ? -in_op1 : in_op1;
  assign b_mag     = (is_signed && in_op2[W-1]) ? -in_op2 : in_op2;

  // One shift-add step: conditionally add multiplicand, then shift right.
  assign add_sum  = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, opnd} : {(W+1){1'b0}});
  assign mul_next = {add_sum, prod[W-1:1]};

  // One restoring-divide step: bring in the next dividend bit, try subtract.
  assign div_shift = {prod[2*W-1:W], prod[W-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd});
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_next  = div_ge ? {div_diff[W-1:0],  prod[W-2:0], 1'b1}
                            : {div_shift[W-1:0], prod[W-2:0], 1'b0};

  // Sign correction applied in FIX. Most-negative / -1 falls out naturally:
  // the magnitude quotient is already the most-negative bit pattern.
  assign mul_fixed = neg_lo ? -prod : prod;
  assign quo_fixed = div_zero ? {W{1'b1}} : (neg_lo ? -prod[W-1:0] : prod[W-1:0]);
  assign rem_fixed = neg_hi ? -prod[2*W-1:W] : prod[2*W-1:W];

  // State register.
  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: IDLE dispatches, MUL/DIV iterate W steps, FIX retires.
  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept && is_mul)      next_state = MUL;
        else if (accept && is_div) next_state = DIV;
      end
      MUL, DIV: begin
        if (flush)                  next_state = IDLE;
        else if (cnt == LAST_STEP)  next_state = FIX;
      end
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath, HI/LO and output stage.
  // NOTE: every register here is a plain flop (no memory arrays), so all of
  // them are cleared on reset; this makes HI/LO and the working state read
  // as zero after any reset, including one that lands mid-operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      hi         <= '0;
      lo         <= '0;
      prod       <= '0;
      opnd       <= '0;
      neg_lo     <= 1'b0;
      neg_hi     <= 1'b0;
      div_zero   <= 1'b0;
      op_is_div  <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mul || is_div) begin
              prod      <= {{W{1'b0}}, a_mag};
              opnd      <= b_mag;
              neg_lo    <= is_signed && (in_op1[W-1] ^ in_op2[W-1]);
              neg_hi    <= is_signed && in_op1[W-1];
              div_zero  <= (in_op2 == '0);
              op_is_div <= is_div;
              cnt       <= '0;
            end
            case (in_op)
              OP_MFHI: begin
                out_result <= hi;
                out_valid  <= 1'b1;
              end
              OP_MFLO: begin
                out_result <= lo;
                out_valid  <= 1'b1;
              end
              OP_MTHI: hi <= in_op1;
              OP_MTLO: lo <= in_op1;
              default: ;
            endcase
          end
        end
        MUL: begin
          if (!flush) begin
            prod <= mul_next;
            cnt  <= cnt + CNT_WIDTH'(1);
          end
        end
        DIV: begin
          if (!flush) begin
            prod <= div_next;
            cnt  <= cnt + CNT_WIDTH'(1);
          end
        end
        FIX: begin
          if (!flush) begin
            if (op_is_div) begin
              hi <= rem_fixed;
              lo <= quo_fixed;
            end else begin
              hi <= mul_fixed[2*W-1:W];
              lo <= mul_fixed[W-1:0];
            end
          end
          cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed self-checking bench for mult_div_unit
// (DATA_WIDTH=32) with hand-computed expected values.
module tb_mult_div_unit;

  localparam logic [3:0] NOP   = 4'd0;
  localparam logic [3:0] MULT  = 4'd1;
  localparam logic [3:0] MULTU = 4'd2;
  localparam logic [3:0] DIV   = 4'd3;
  localparam logic [3:0] DIVU  = 4'd4;
  localparam logic [3:0] MFHI  = 4'd5;
  localparam logic [3:0] MFLO  = 4'd6;
  localparam logic [3:0] MTHI  = 4'd7;
  localparam logic [3:0] MTLO  = 4'd8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = NOP;
  logic [31:0] in_op1 = '0;
  logic [31:0] in_op2 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic        busy;

  int checks = 0;
  int failures = 0;

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_op1     (in_op1),
    .in_op2     (in_op2),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one request, wait (bounded) for in_ready, return #1 after the
  // acceptance edge with in_valid dropped.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    in_valid = 1'b1;
    in_op    = op;
    in_op1   = a;
    in_op2   = b;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op    = NOP;
  endtask

  // Count negedges with in_ready low after an acceptance (bounded).
  task automatic wait_ready(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready || n >= 100) break;
      n++;
    end
  endtask

  task automatic expect_hilo(input string tag, input logic [31:0] hi_exp, input logic [31:0] lo_exp);
    send(MFHI, '0, '0);
    check({tag, "_hi_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_hi"}, out_result, hi_exp);
    send(MFLO, '0, '0);
    check({tag, "_lo_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_lo"}, out_result, lo_exp);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi_exp, input logic [31:0] lo_exp);
    int n;
    send(op, a, b);
    wait_ready(n);
    check({tag, "_busy_cycles"}, n, 32'd33);
    expect_hilo(tag, hi_exp, lo_exp);
  endtask

  initial begin
    int n;
    // Reset state while rst is held.
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    expect_hilo("rst", 32'h0, 32'h0);

    // Multiply / divide vectors.
    run_op("mult_m1x2",  MULT,  32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("multu_m1x2", MULTU, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE);
    run_op("mult_maxmin", MULT, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000);
    run_op("div_m7_2",   DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_100_m7", DIV,   32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2);
    run_op("divu_7_0",   DIVU,  32'd7,        32'h0,        32'h00000007, 32'hFFFFFFFF);
    run_op("div_m5_0",   DIV,   32'hFFFFFFFB, 32'h0,        32'hFFFFFFFB, 32'hFFFFFFFF);
    run_op("divu_big",   DIVU,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF);
    run_op("div_ovf",    DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // NOP and reserved codes leave HI/LO alone.
    send(4'd12, 32'h1111, 32'h2222);
    send(NOP, 32'h3333, 32'h4444);
    expect_hilo("nop", 32'h00000000, 32'h80000000);

    // MTHI then MFHI held by back-pressure.
    @(negedge clk);
    send(MTHI, 32'h1234, '0);
    check("mthi_no_out", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
    send(MFHI, '0, '0);
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_result", out_result, 32'h00001234);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    // flush in IDLE blocks acceptance but keeps the pending result.
    flush = 1'b1;
    #1;
    check("flush_idle_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("flush_idle_valid", {31'd0, out_valid}, 32'd1);
    flush = 1'b0;
    out_ready = 1'b1;
    #1;
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("release_valid", {31'd0, out_valid}, 32'd0);

    // Flush mid-multiply: HI/LO unchanged.
    send(MTLO, 32'hAAAA5555, '0);
    send(MULTU, 32'd5, 32'd6);
    repeat (10) @(negedge clk);
    check("flush_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy_after", {31'd0, busy}, 32'd0);
    expect_hilo("flush", 32'h00001234, 32'hAAAA5555);

    // Full MULTU 5x6 afterwards retires normally.
    run_op("multu_5x6", MULTU, 32'd5, 32'd6, 32'h0, 32'd30);

    // Reset mid-divide.
    send(MTHI, 32'h55, '0);
    send(DIVU, 32'd100, 32'd3);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_result", out_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    expect_hilo("midrst", 32'h0, 32'h0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
